// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the central sequencer.
// Carries raw hazard indications in, and stage enables/clears, halt and counters out.
// master = datapath side (drives hazards), slave = sequencer side (drives controls).
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             ld_use_hazard;
  logic             mispredict;
  logic             dm_busy;
  logic             halt_ps4;
  logic             valid_ps4;
  logic             resume;
  logic [4:0]       en_stage;
  logic [4:0]       clear_stage;
  logic             halted;
  logic             dm_timeout;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] inst_cnt;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output en, ld_use_hazard, mispredict, dm_busy, halt_ps4, valid_ps4, resume,
    input  en_stage, clear_stage, halted, dm_timeout,
    input  cycle_cnt, inst_cnt, bubble_cnt, flush_cnt
  );

  modport slave (
    input  en, ld_use_hazard, mispredict, dm_busy, halt_ps4, valid_ps4, resume,
    output en_stage, clear_stage, halted, dm_timeout,
    output cycle_cnt, inst_cnt, bubble_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central 5-stage pipeline sequencer: resolves hazards into stage enables/clears, halt, counters.
// Latency: en_stage/clear_stage are same-cycle combinational; state, halted and counters update next clock.
// Backpressure: dm_busy freezes all stages; en=0 freezes everything including state and counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W      = 16,
  parameter int DM_TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int WD_W = $clog2(DM_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(DM_TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_LU_BUBBLE = 2'd1,
    S_DM_WAIT   = 2'd2,
    S_HALT      = 2'd3
  } state_e;

  state_e           state_q;
  logic             halted_q;
  logic             dm_timeout_q;
  logic [WD_W-1:0]  wd_q;
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] inst_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic [4:0]       en_stage_c;
  logic [4:0]       clear_stage_c;
  logic             take_halt;
  logic             take_busy;
  logic             take_flush;
  logic             take_bubble;
  logic [WD_W-1:0]  wd_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Priority resolution of hazards into stage enables/clears for this cycle.
  always_comb begin
    en_stage_c    = 5'b00000;
    clear_stage_c = 5'b00000;
    take_halt     = 1'b0;
    take_busy     = 1'b0;
    take_flush    = 1'b0;
    take_bubble   = 1'b0;
    if (hz.en && state_q != S_HALT) begin
      if (hz.halt_ps4 && hz.valid_ps4) begin
        // Let WB commit the syscall; younger hazards are moot once halted.
        en_stage_c = 5'b11111;
        take_halt  = 1'b1;
      end else if (hz.dm_busy) begin
        // Full freeze; the datapath keeps any mispredict pending until busy drops.
        take_busy = 1'b1;
      end else if (hz.mispredict) begin
        en_stage_c    = 5'b11111;
        clear_stage_c = 5'b01110;
        take_flush    = 1'b1;
      end else if (hz.ld_use_hazard && state_q != S_LU_BUBBLE) begin
        // Compare is stale right after a bubble, so it is masked in LU_BUBBLE.
        en_stage_c    = 5'b11000;
        clear_stage_c = 5'b01000;
        take_bubble   = 1'b1;
      end else begin
        en_stage_c = 5'b11111;
      end
    end
  end

  assign wd_inc = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;

  // Sequencer state, registered flags, watchdog and saturating counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      halted_q     <= 1'b0;
      dm_timeout_q <= 1'b0;
      wd_q         <= '0;
      cycle_cnt_q  <= '0;
      inst_cnt_q   <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else if (hz.en) begin
      if (state_q != S_HALT) cycle_cnt_q <= sat_inc(cycle_cnt_q);
      if (hz.valid_ps4 && en_stage_c[4]) inst_cnt_q <= sat_inc(inst_cnt_q);
      if (take_flush) flush_cnt_q <= sat_inc(flush_cnt_q);
      if (take_bubble) bubble_cnt_q <= sat_inc(bubble_cnt_q);

      if (state_q == S_HALT) begin
        if (hz.resume) begin
          state_q  <= S_RUN;
          halted_q <= 1'b0;
        end
      end else if (take_halt) begin
        state_q  <= S_HALT;
        halted_q <= 1'b1;
        wd_q     <= '0;
      end else if (take_busy) begin
        state_q <= S_DM_WAIT;
        wd_q    <= wd_inc;
        if (wd_inc == WD_MAX) dm_timeout_q <= 1'b1;
      end else if (take_bubble) begin
        state_q <= S_LU_BUBBLE;
        wd_q    <= '0;
      end else begin
        state_q <= S_RUN;
        wd_q    <= '0;
      end
    end
  end

  assign hz.en_stage    = en_stage_c;
  assign hz.clear_stage = clear_stage_c;
  assign hz.halted      = halted_q;
  assign hz.dm_timeout  = dm_timeout_q;
  assign hz.cycle_cnt   = cycle_cnt_q;
  assign hz.inst_cnt    = inst_cnt_q;
  assign hz.bubble_cnt  = bubble_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic against a behavioural model.
// A second CNT_W=4 instance exercises counter saturation and reset during a memory stall.
// All inputs change on the falling edge; outputs are sampled 2 time units later.
module tb_pipeline_hazard_ctrl;

  localparam int MAXC = 65535;
  localparam int TMO  = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_s_n;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) hz ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  hs ();

  pipeline_hazard_ctrl #(.CNT_W(16), .DM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .hz(hz)
  );
  pipeline_hazard_ctrl #(.CNT_W(4), .DM_TIMEOUT(TMO)) dut_s (
    .clk(clk), .rst_n(rst_s_n), .hz(hs)
  );

  int n_chk = 0;
  int n_bad = 0;

  // Behavioural model: plain flags and integers.
  bit m_halted, m_masked, m_to;
  int m_busy, m_cyc, m_inst, m_bub, m_flush;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  task automatic model_reset();
    m_halted = 0; m_masked = 0; m_to = 0; m_busy = 0;
    m_cyc = 0; m_inst = 0; m_bub = 0; m_flush = 0;
  endtask

  task automatic drive(input bit e, ld, mp, bz, hl, vl, rs);
    hz.en = e; hz.ld_use_hazard = ld; hz.mispredict = mp; hz.dm_busy = bz;
    hz.halt_ps4 = hl; hz.valid_ps4 = vl; hz.resume = rs;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    chk("rst_halted", 32'(hz.halted), 0);
    chk("rst_tmo", 32'(hz.dm_timeout), 0);
    chk("rst_cyc", 32'(hz.cycle_cnt), 0);
    chk("rst_inst", 32'(hz.inst_cnt), 0);
    chk("rst_bub", 32'(hz.bubble_cnt), 0);
    chk("rst_flush", 32'(hz.flush_cnt), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: apply inputs, compare against the model, then advance the model.
  task automatic step(input bit e, ld, mp, bz, hl, vl, rs);
    logic [4:0] ee, ec;
    @(negedge clk);
    drive(e, ld, mp, bz, hl, vl, rs);
    #2;
    ee = 5'b00000;
    ec = 5'b00000;
    if (e && !m_halted) begin
      if (hl && vl)               ee = 5'b11111;
      else if (bz)                ee = 5'b00000;
      else if (mp)                begin ee = 5'b11111; ec = 5'b01110; end
      else if (ld && !m_masked)   begin ee = 5'b11000; ec = 5'b01000; end
      else                        ee = 5'b11111;
    end
    chk("en_stage", 32'(hz.en_stage), 32'(ee));
    chk("clear_stage", 32'(hz.clear_stage), 32'(ec));
    chk("halted", 32'(hz.halted), 32'(m_halted));
    chk("dm_timeout", 32'(hz.dm_timeout), 32'(m_to));
    chk("cycle_cnt", 32'(hz.cycle_cnt), 32'(m_cyc));
    chk("inst_cnt", 32'(hz.inst_cnt), 32'(m_inst));
    chk("bubble_cnt", 32'(hz.bubble_cnt), 32'(m_bub));
    chk("flush_cnt", 32'(hz.flush_cnt), 32'(m_flush));
    @(posedge clk);
    if (e) begin
      if (!m_halted) m_cyc = sat(m_cyc);
      if (vl && ee[4]) m_inst = sat(m_inst);
      if (m_halted) begin
        if (rs) m_halted = 0;
      end else if (hl && vl) begin
        m_halted = 1; m_busy = 0; m_masked = 0;
      end else if (bz) begin
        m_busy++;
        if (m_busy >= TMO) m_to = 1;
        m_masked = 0;
      end else begin
        m_busy = 0;
        if (mp) begin
          m_flush = sat(m_flush); m_masked = 0;
        end else if (ld && !m_masked) begin
          m_bub = sat(m_bub); m_masked = 1;
        end else begin
          m_masked = 0;
        end
      end
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    rst_s_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    hs.en = 0; hs.ld_use_hazard = 0; hs.mispredict = 0; hs.dm_busy = 0;
    hs.halt_ps4 = 0; hs.valid_ps4 = 0; hs.resume = 0;
    model_reset();

    // Saturation and reset mid-DM_WAIT on the narrow-counter instance.
    @(negedge clk);
    rst_s_n = 1'b1;
    hs.en = 1; hs.valid_ps4 = 1;
    repeat (20) @(negedge clk);
    #2;
    chk("sat_cyc", 32'(hs.cycle_cnt), 15);
    chk("sat_inst", 32'(hs.inst_cnt), 15);
    @(negedge clk);
    hs.dm_busy = 1;
    repeat (3) @(negedge clk);
    #2;
    chk("s_busy_en", 32'(hs.en_stage), 0);
    chk("s_busy_cyc", 32'(hs.cycle_cnt), 15);
    rst_s_n = 1'b0;
    #2;
    chk("s_rst_cyc", 32'(hs.cycle_cnt), 0);
    chk("s_rst_inst", 32'(hs.inst_cnt), 0);
    chk("s_rst_tmo", 32'(hs.dm_timeout), 0);
    @(negedge clk);
    rst_s_n = 1'b1;
    hs.dm_busy = 0;
    #2;
    chk("s_run_en", 32'(hs.en_stage), 32'h1F);
    @(negedge clk);
    #2;
    chk("s_run_cyc", 32'(hs.cycle_cnt), 1);

    // 1: ten clean cycles.
    do_reset();
    repeat (10) step(1, 0, 0, 0, 0, 1, 0);
    chk("t1_cyc", 32'(hz.cycle_cnt), 10);
    chk("t1_inst", 32'(hz.inst_cnt), 10);

    // 2: single load-use pulse, then held for three cycles.
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    chk("t2_bub1", 32'(hz.bubble_cnt), 1);
    repeat (3) step(1, 1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    chk("t2_bub3", 32'(hz.bubble_cnt), 3);

    // 3: mispredict beats load-use.
    step(1, 1, 1, 0, 0, 1, 0);
    chk("t3_flush", 32'(hz.flush_cnt), 1);
    chk("t3_bub", 32'(hz.bubble_cnt), 3);

    // 4: long memory stall trips the watchdog; the flag is sticky.
    repeat (TMO + 2) step(1, 0, 0, 1, 0, 1, 0);
    repeat (3) step(1, 0, 0, 0, 0, 1, 0);
    chk("t4_tmo", 32'(hz.dm_timeout), 1);

    // 5: halt wins over mispredict, hold, then resume.
    step(1, 0, 1, 0, 1, 1, 0);
    chk("t5_halted", 32'(hz.halted), 1);
    chk("t5_noflush", 32'(hz.flush_cnt), 1);
    repeat (5) step(1, 1, 1, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 1, 0);
    chk("t5_resumed", 32'(hz.halted), 0);

    // Reset while halted.
    step(1, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    do_reset();
    step(1, 0, 0, 0, 0, 1, 0);

    // Random traffic with occasional busy bursts and resets.
    for (int i = 0; i < 1500; i++) begin
      bit e, ld, mp, bz, hl, vl, rs;
      e  = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 3) == 0);
      mp = ($urandom_range(0, 9) == 0);
      bz = ($urandom_range(0, 6) == 0);
      hl = ($urandom_range(0, 19) == 0);
      vl = ($urandom_range(0, 9) < 7);
      rs = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 249) == 0) do_reset();
      if ($urandom_range(0, 99) == 0) begin
        int len;
        len = $urandom_range(2, 12);
        for (int k = 0; k < len; k++) step(1, ld, mp, 1, 0, vl, 0);
      end
      step(e, ld, mp, bz, hl, vl, rs);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
